// File: rtl/hamming_pkg.sv
// Shared helpers for the Hamming block format used by the encoder and decoder.
//
// Contents:
//   hamming_parity_width(data_width) : smallest P with 2**P - P - 1 >= data_width
//   is_power_of_two(position)        : 1 when a 1-based block position holds a parity bit
package hamming_pkg;

   function automatic int unsigned hamming_parity_width(input int unsigned data_width);
      int unsigned p;
      p = 1;
      while (((32'd1 << p) - p - 1) < data_width) begin
         p++;
      end
      return p;
   endfunction

   function automatic logic is_power_of_two(input int unsigned position);
      return (position != 0) && ((position & (position - 1)) == 0);
   endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome generator for one Hamming block.
//
// The syndrome is the XOR of the 1-based positions of every set bit. A block as
// produced by the encoder has syndrome 0; a single flipped bit yields its position.
//
// Ports:
//   block     in   BLOCK_WIDTH   received block, bit index = position - 1
//   syndrome  out  PARITY_WIDTH  XOR of the positions of all set bits
module hamming_syndrome
   import hamming_pkg::*;
#(
   parameter int unsigned BLOCK_WIDTH  = 12,
   parameter int unsigned PARITY_WIDTH = 4
) (
   input  logic [BLOCK_WIDTH-1:0]  block,
   output logic [PARITY_WIDTH-1:0] syndrome
);

   always_comb begin
      syndrome = '0;
      for (int unsigned i = 0; i < BLOCK_WIDTH; i++) begin
         if (block[i]) begin
            syndrome = syndrome ^ PARITY_WIDTH'(i + 1);
         end
      end
   end

endmodule

// File: rtl/hamming_stream_decoder.sv
// Streaming Hamming decoder with a two-stage valid/ready pipeline.
//
// Stage 1 captures the received block together with its syndrome. Stage 2 holds the
// corrected (or raw, when uncorrectable) data word, the syndrome and the status flags.
// Two saturating counters track delivered corrected and uncorrectable blocks.
//
// Ports:
//   clock                in   1              rising-edge clock
//   reset                in   1              synchronous, active-high
//   in_block             in   BLOCK_WIDTH    received block (parity and data interleaved)
//   in_valid             in   1              in_block valid
//   in_ready             out  1              block accepted this cycle when in_valid
//   out_data             out  DATA_WIDTH     data word, corrected when possible
//   out_syndrome         out  PARITY_WIDTH   raw syndrome of the block
//   out_corrected        out  1              a single-bit error was fixed
//   out_uncorrectable    out  1              syndrome points past the block; data is raw
//   out_valid            out  1              out_* valid
//   out_ready            in   1              consumer accepts out_* this cycle
//   clear_counters       in   1              zero both counters (wins over an increment)
//   corrected_count      out  COUNTER_WIDTH  delivered blocks with out_corrected set
//   uncorrectable_count  out  COUNTER_WIDTH  delivered blocks with out_uncorrectable set
module hamming_stream_decoder
   import hamming_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned COUNTER_WIDTH = 16,
   localparam int unsigned PARITY_WIDTH = hamming_parity_width(DATA_WIDTH),
   localparam int unsigned BLOCK_WIDTH  = DATA_WIDTH + PARITY_WIDTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [BLOCK_WIDTH-1:0]   in_block,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic [PARITY_WIDTH-1:0]  out_syndrome,
   output logic                     out_corrected,
   output logic                     out_uncorrectable,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic                     clear_counters,
   output logic [COUNTER_WIDTH-1:0] corrected_count,
   output logic [COUNTER_WIDTH-1:0] uncorrectable_count
);

   // ------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------
   logic                     s1_valid_q;
   logic [BLOCK_WIDTH-1:0]   s1_block_q;
   logic [PARITY_WIDTH-1:0]  s1_syndrome_q;

   logic                     s2_valid_q;
   logic [DATA_WIDTH-1:0]    s2_data_q;
   logic [PARITY_WIDTH-1:0]  s2_syndrome_q;
   logic                     s2_corrected_q;
   logic                     s2_uncorrectable_q;

   logic [COUNTER_WIDTH-1:0] corrected_count_q, corrected_count_d;
   logic [COUNTER_WIDTH-1:0] uncorrectable_count_q, uncorrectable_count_d;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic s2_load;
   logic s1_load;
   logic out_fire;

   // No skid buffer: in_ready depends combinationally on out_ready.
   assign s2_load  = !s2_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = s1_load;
   assign out_fire = s2_valid_q && out_ready;

   // ------------------------------------------------------------------
   // Stage 1 syndrome
   // ------------------------------------------------------------------
   logic [PARITY_WIDTH-1:0] in_syndrome;

   hamming_syndrome #(
      .BLOCK_WIDTH  (BLOCK_WIDTH),
      .PARITY_WIDTH (PARITY_WIDTH)
   ) u_syndrome (
      .block    (in_block),
      .syndrome (in_syndrome)
   );

   // ------------------------------------------------------------------
   // Correction and data extraction (feeds stage 2)
   // ------------------------------------------------------------------
   logic [BLOCK_WIDTH-1:0] flip_mask;
   logic [BLOCK_WIDTH-1:0] fixed_block;
   logic [DATA_WIDTH-1:0]  data_d;
   logic                   corrected_d;
   logic                   uncorrectable_d;

   // A syndrome past the last position matches no mask bit, so the block passes raw.
   always_comb begin
      flip_mask = '0;
      for (int unsigned i = 0; i < BLOCK_WIDTH; i++) begin
         flip_mask[i] = (s1_syndrome_q == PARITY_WIDTH'(i + 1));
      end
   end

   assign fixed_block     = s1_block_q ^ flip_mask;
   assign corrected_d     = |flip_mask;
   assign uncorrectable_d = (s1_syndrome_q > PARITY_WIDTH'(BLOCK_WIDTH));

   // Data bits occupy the non-power-of-two positions in ascending order, LSB first.
   always_comb begin
      int unsigned k;
      k      = 0;
      data_d = '0;
      for (int unsigned p = 1; p <= BLOCK_WIDTH; p++) begin
         if (!is_power_of_two(p)) begin
            data_d[k] = fixed_block[p-1];
            k++;
         end
      end
   end

   // ------------------------------------------------------------------
   // Pipeline registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q         <= 1'b0;
         s1_block_q         <= '0;
         s1_syndrome_q      <= '0;
         s2_valid_q         <= 1'b0;
         s2_data_q          <= '0;
         s2_syndrome_q      <= '0;
         s2_corrected_q     <= 1'b0;
         s2_uncorrectable_q <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_block_q    <= in_block;
               s1_syndrome_q <= in_syndrome;
            end
         end
         // Data fields only move when a block advances, keeping out_* steady otherwise.
         if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_data_q          <= data_d;
               s2_syndrome_q      <= s1_syndrome_q;
               s2_corrected_q     <= corrected_d;
               s2_uncorrectable_q <= uncorrectable_d;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Error counters
   // ------------------------------------------------------------------
   always_comb begin
      corrected_count_d     = corrected_count_q;
      uncorrectable_count_d = uncorrectable_count_q;
      if (clear_counters) begin
         corrected_count_d     = '0;
         uncorrectable_count_d = '0;
      end else if (out_fire) begin
         if (s2_corrected_q && (corrected_count_q != '1)) begin
            corrected_count_d = corrected_count_q + COUNTER_WIDTH'(1);
         end
         if (s2_uncorrectable_q && (uncorrectable_count_q != '1)) begin
            uncorrectable_count_d = uncorrectable_count_q + COUNTER_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         corrected_count_q     <= '0;
         uncorrectable_count_q <= '0;
      end else begin
         corrected_count_q     <= corrected_count_d;
         uncorrectable_count_q <= uncorrectable_count_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign out_valid           = s2_valid_q;
   assign out_data            = s2_data_q;
   assign out_syndrome        = s2_syndrome_q;
   assign out_corrected       = s2_corrected_q;
   assign out_uncorrectable   = s2_uncorrectable_q;
   assign corrected_count     = corrected_count_q;
   assign uncorrectable_count = uncorrectable_count_q;

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Self-checking bench for hamming_stream_decoder.
//
// u_dut4 (DATA_WIDTH=4) runs directed constant checks; u_dut8 (DATA_WIDTH=8,
// COUNTER_WIDTH=2) runs directed and randomized streams against a reference model.
module tb_hamming_stream_decoder;

   localparam int unsigned DW  = 8;
   localparam int unsigned PW  = 4;
   localparam int unsigned BW  = 12;
   localparam int unsigned CW  = 2;
   localparam int unsigned DW4 = 4;
   localparam int unsigned PW4 = 3;
   localparam int unsigned BW4 = 7;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset;
   logic [BW-1:0] in_block;
   logic          in_valid, in_ready;
   logic [DW-1:0] out_data;
   logic [PW-1:0] out_syndrome;
   logic          out_corrected, out_uncorrectable, out_valid, out_ready, clear_counters;
   logic [CW-1:0] corrected_count, uncorrectable_count;

   logic [BW4-1:0] in_block_4;
   logic           in_valid_4, in_ready_4;
   logic [DW4-1:0] out_data_4;
   logic [PW4-1:0] out_syndrome_4;
   logic           out_corrected_4, out_uncorrectable_4, out_valid_4, out_ready_4;
   logic           clear_counters_4;
   logic [15:0]    corrected_count_4, uncorrectable_count_4;

   hamming_stream_decoder #(.DATA_WIDTH(DW), .COUNTER_WIDTH(CW)) u_dut8 (
      .clock               (clock),
      .reset               (reset),
      .in_block            (in_block),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .out_data            (out_data),
      .out_syndrome        (out_syndrome),
      .out_corrected       (out_corrected),
      .out_uncorrectable   (out_uncorrectable),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .clear_counters      (clear_counters),
      .corrected_count     (corrected_count),
      .uncorrectable_count (uncorrectable_count)
   );

   hamming_stream_decoder #(.DATA_WIDTH(DW4), .COUNTER_WIDTH(16)) u_dut4 (
      .clock               (clock),
      .reset               (reset),
      .in_block            (in_block_4),
      .in_valid            (in_valid_4),
      .in_ready            (in_ready_4),
      .out_data            (out_data_4),
      .out_syndrome        (out_syndrome_4),
      .out_corrected       (out_corrected_4),
      .out_uncorrectable   (out_uncorrectable_4),
      .out_valid           (out_valid_4),
      .out_ready           (out_ready_4),
      .clear_counters      (clear_counters_4),
      .corrected_count     (corrected_count_4),
      .uncorrectable_count (uncorrectable_count_4)
   );

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   typedef struct {
      logic [31:0] data;
      int          syn;
      bit          corr;
      bit          unc;
   } res_t;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_parity_pos(input int p);
      for (int i = 0; i < 31; i++) begin
         if (p == (1 << i)) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Place data bits, then choose parity bits so the XOR of set positions is zero.
   function automatic logic [31:0] encode(input int bw, input logic [31:0] data);
      logic [31:0] blk;
      int k;
      int s;
      blk = '0;
      k   = 0;
      s   = 0;
      for (int p = 1; p <= bw; p++) begin
         if (!is_parity_pos(p)) begin
            blk[p-1] = data[k];
            if (data[k]) s = s ^ p;
            k++;
         end
      end
      for (int i = 0; (1 << i) <= bw; i++) begin
         blk[(1 << i) - 1] = s[i];
      end
      return blk;
   endfunction

   function automatic res_t decode(input int bw, input logic [31:0] blk_in);
      res_t r;
      logic [31:0] blk;
      int k;
      blk   = blk_in;
      r.syn = 0;
      for (int p = 1; p <= bw; p++) begin
         if (blk[p-1]) r.syn = r.syn ^ p;
      end
      r.corr = (r.syn >= 1) && (r.syn <= bw);
      r.unc  = (r.syn > bw);
      if (r.corr) blk[r.syn-1] = ~blk[r.syn-1];
      r.data = '0;
      k      = 0;
      for (int p = 1; p <= bw; p++) begin
         if (!is_parity_pos(p)) begin
            r.data[k] = blk[p-1];
            k++;
         end
      end
      return r;
   endfunction

   function automatic logic [BW-1:0] gen_block(input int nerr);
      logic [31:0] b;
      int p1;
      int p2;
      b  = encode(BW, 32'($urandom_range(0, 255)));
      p1 = int'($urandom_range(0, BW - 1));
      p2 = (p1 + 1 + int'($urandom_range(0, BW - 2))) % BW;
      if (nerr >= 1) b[p1] = ~b[p1];
      if (nerr >= 2) b[p2] = ~b[p2];
      return b[BW-1:0];
   endfunction

   // ------------------------------------------------------------------
   // Stream driver and scoreboard for u_dut8
   // ------------------------------------------------------------------
   logic [BW-1:0] stim_q[$];
   res_t          exp_q[$];
   int            m_corr = 0;
   int            m_unc  = 0;
   int            wait_cnt = 0;

   // Called at posedge+1; returns at the next posedge+1.
   task automatic step(input bit vld_en, input bit ordy, input bit clr);
      res_t r;
      in_valid       = vld_en && (stim_q.size() > 0);
      in_block       = (stim_q.size() > 0) ? stim_q[0] : '0;
      out_ready      = ordy;
      clear_counters = clr;
      @(negedge clock);
      check("corr_count", 32'(corrected_count), 32'(m_corr));
      check("unc_count", 32'(uncorrectable_count), 32'(m_unc));
      check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || ordy));
      if (out_valid) begin
         wait_cnt = 0;
         if (exp_q.size() == 0) begin
            check("spurious_out", 32'(out_valid), 32'd0);
         end else begin
            r = exp_q[0];
            check("out_data", 32'(out_data), r.data);
            check("out_syndrome", 32'(out_syndrome), 32'(r.syn));
            check("out_corrected", 32'(out_corrected), 32'(r.corr));
            check("out_uncorrectable", 32'(out_uncorrectable), 32'(r.unc));
            if (ordy) begin
               void'(exp_q.pop_front());
               if (!clr) begin
                  if (r.corr && m_corr < 3) m_corr++;
                  if (r.unc && m_unc < 3) m_unc++;
               end
            end
         end
      end else if (exp_q.size() > 0) begin
         wait_cnt++;
         if (wait_cnt > 1) check("latency", 32'(wait_cnt), 32'd1);
      end
      if (clr) begin
         m_corr = 0;
         m_unc  = 0;
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(decode(BW, 32'(stim_q[0])));
         void'(stim_q.pop_front());
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      in_valid       = 1'b0;
      out_ready      = 1'b0;
      clear_counters = 1'b0;
      @(posedge clock);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_corr_count", 32'(corrected_count), 32'd0);
      check("rst_unc_count", 32'(uncorrectable_count), 32'd0);
      reset = 1'b0;
      exp_q.delete();
      stim_q.delete();
      m_corr   = 0;
      m_unc    = 0;
      wait_cnt = 0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      reset            = 1'b1;
      in_block         = '0;
      in_valid         = 1'b0;
      out_ready        = 1'b0;
      clear_counters   = 1'b0;
      in_block_4       = '0;
      in_valid_4       = 1'b0;
      out_ready_4      = 1'b0;
      clear_counters_4 = 1'b0;
      @(posedge clock);
      #1;
      do_reset();
      check("rst4_out_valid", 32'(out_valid_4), 32'd0);
      check("rst4_in_ready", 32'(in_ready_4), 32'd1);

      // Clean block, 4-bit data.
      in_block_4  = 7'h55;
      in_valid_4  = 1'b1;
      out_ready_4 = 1'b1;
      @(negedge clock);
      check("t1_in_ready", 32'(in_ready_4), 32'd1);
      @(posedge clock);
      #1;
      in_valid_4 = 1'b0;
      @(negedge clock);
      check("t1_lat_early", 32'(out_valid_4), 32'd0);
      @(posedge clock);
      #1;
      check("t1_out_valid", 32'(out_valid_4), 32'd1);
      check("t1_out_data", 32'(out_data_4), 32'hB);
      check("t1_syndrome", 32'(out_syndrome_4), 32'd0);
      check("t1_corrected", 32'(out_corrected_4), 32'd0);
      check("t1_uncorr", 32'(out_uncorrectable_4), 32'd0);
      @(posedge clock);
      #1;

      // Position 5 flipped.
      in_block_4 = 7'h45;
      in_valid_4 = 1'b1;
      @(posedge clock);
      #1;
      in_valid_4 = 1'b0;
      @(posedge clock);
      #1;
      check("t2_out_valid", 32'(out_valid_4), 32'd1);
      check("t2_out_data", 32'(out_data_4), 32'hB);
      check("t2_syndrome", 32'(out_syndrome_4), 32'd5);
      check("t2_corrected", 32'(out_corrected_4), 32'd1);
      @(posedge clock);
      #1;
      check("t2_corr_count", 32'(corrected_count_4), 32'd1);
      check("t2_drained", 32'(out_valid_4), 32'd0);

      // Double error with syndrome past the block, held under stall.
      stim_q.push_back(12'h801);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("t3_out_valid", 32'(out_valid), 32'd1);
      check("t3_out_data", 32'(out_data), 32'h80);
      check("t3_syndrome", 32'(out_syndrome), 32'd13);
      check("t3_uncorr", 32'(out_uncorrectable), 32'd1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);

      // Ten back-to-back blocks with a stall on cycles 3..6.
      for (int i = 0; i < 10; i++) stim_q.push_back(gen_block(0));
      for (int c = 0; c < 16; c++) step(1'b1, !(c >= 3 && c <= 6), 1'b0);
      check("t4_all_delivered", 32'(exp_q.size() + stim_q.size()), 32'd0);

      // Counter saturation, then clear on a corrected handshake.
      for (int i = 0; i < 5; i++) stim_q.push_back(gen_block(1));
      for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 1'b0);
      check("t5_saturated", 32'(corrected_count), 32'd3);
      stim_q.push_back(gen_block(1));
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      check("t5_clear_prio", 32'(corrected_count), 32'd0);

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         if (stim_q.size() == 0) stim_q.push_back(gen_block(int'($urandom_range(0, 2))));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      end

      // Reset with two blocks in flight, then no stale output.
      stim_q.delete();
      for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0);
      stim_q.push_back(gen_block(1));
      stim_q.push_back(gen_block(0));
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("t6_in_flight", 32'(exp_q.size()), 32'd2);
      do_reset();
      for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 1'b0);

      // Short random run after reset, then drain with a bounded wait.
      for (int c = 0; c < 60; c++) begin
         if (stim_q.size() == 0) stim_q.push_back(gen_block(int'($urandom_range(0, 2))));
         step(1'b1, $urandom_range(0, 1) != 0, 1'b0);
      end
      stim_q.delete();
      for (int c = 0; c < 10 && exp_q.size() > 0; c++) step(1'b0, 1'b1, 1'b0);
      check("final_drain", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
